// File: rtl/scan_bus_pkg.sv
// Shared types for the scan bus router: FSM states, decoded target kinds
// and the address region-select convention.
package scan_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRAM   = 2'd0,
        REG    = 2'd1,
        STATUS = 2'd2,
        ERR    = 2'd3
    } target_kind_t;

    // The address MSB selects register space when set, SRAM when clear.
    localparam logic REGION_REG = 1'b1;

    function automatic logic is_reg_region(input logic msb);
        return (msb == REGION_REG);
    endfunction

endpackage

// File: rtl/scan_bus_decode.sv
// Combinational decode of a scan request into a target kind and a one-hot
// register select.
module scan_bus_decode
    import scan_bus_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int NUM_REGS = 4
) (
    input  logic                ren,
    input  logic                wen,
    input  logic [ADDR_W-1:0]   addr,
    output target_kind_t        kind,
    output logic [NUM_REGS-1:0] reg_sel
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

    logic [IDX_W-1:0] idx_s;
    logic             unused_addr_s;

    assign idx_s = addr[IDX_W-1:0];
    // Address bits between the SRAM word address and the region bit are don't-care.
    assign unused_addr_s = ^addr;

    // One-hot register select from the low index bits.
    always_comb begin
        reg_sel = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_sel[i] = (idx_s == IDX_W'(i));
        end
    end

    // Target classification; simultaneous read and write is always illegal.
    always_comb begin
        kind = ERR;
        if (ren && wen) begin
            kind = ERR;
        end else if (!is_reg_region(addr[ADDR_W-1])) begin
            kind = SRAM;
        end else if (idx_s < STATUS_IDX) begin
            kind = REG;
        end else if ((idx_s == STATUS_IDX) && ren) begin
            kind = STATUS;
        end else begin
            kind = ERR;
        end
    end

endmodule

// File: rtl/scan_bus_router.sv
// Registered router from the scan request port to the FFT SRAM, the control
// registers and the status word, with a per-transaction ready timeout.
module scan_bus_router
    import scan_bus_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int SRAM_AW  = 9,
    parameter int NUM_REGS = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scan_ren,
    input  logic                       scan_wen,
    input  logic [ADDR_W-1:0]          scan_addr,
    input  logic [DATA_W-1:0]          scan_wdata,
    output logic [DATA_W-1:0]          scan_rdata,
    output logic                       scan_ready,
    output logic                       scan_err,
    output logic                       scan_busy,
    output logic                       sram_ren,
    output logic                       sram_wen,
    output logic [SRAM_AW-1:0]         sram_addr,
    output logic [DATA_W-1:0]          sram_wdata,
    input  logic [DATA_W-1:0]          sram_rdata,
    input  logic                       sram_ready,
    output logic [NUM_REGS-1:0]        reg_ren,
    output logic [NUM_REGS-1:0]        reg_wen,
    output logic [DATA_W-1:0]          reg_wdata,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    input  logic [NUM_REGS-1:0]        reg_ready,
    input  logic [DATA_W-1:0]          status_in
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                tgt_sram_r;
    logic                write_r;
    logic [NUM_REGS-1:0] reg_sel_r;

    target_kind_t        kind_s;
    logic [NUM_REGS-1:0] reg_sel_s;
    logic                sel_ready_s;
    logic [DATA_W-1:0]   sel_rdata_s;
    logic [DATA_W-1:0]   reg_rdata_mux_s;

    scan_bus_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .ren     (scan_ren),
        .wen     (scan_wen),
        .addr    (scan_addr),
        .kind    (kind_s),
        .reg_sel (reg_sel_s)
    );

    // Only the captured target's ready and read data are visible to the FSM.
    always_comb begin
        reg_rdata_mux_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_rdata_mux_s = reg_rdata_mux_s
                            | (reg_rdata[i*DATA_W +: DATA_W] & {DATA_W{reg_sel_r[i]}});
        end
        if (tgt_sram_r) begin
            sel_ready_s = sram_ready;
            sel_rdata_s = sram_rdata;
        end else begin
            sel_ready_s = |(reg_ready & reg_sel_r);
            sel_rdata_s = reg_rdata_mux_s;
        end
    end

    // Request FSM, timeout counter and registered response/strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            tgt_sram_r <= 1'b0;
            write_r    <= 1'b0;
            reg_sel_r  <= {NUM_REGS{1'b0}};
            scan_rdata <= {DATA_W{1'b0}};
            scan_ready <= 1'b0;
            scan_err   <= 1'b0;
            scan_busy  <= 1'b0;
            sram_ren   <= 1'b0;
            sram_wen   <= 1'b0;
            sram_addr  <= {SRAM_AW{1'b0}};
            sram_wdata <= {DATA_W{1'b0}};
            reg_ren    <= {NUM_REGS{1'b0}};
            reg_wen    <= {NUM_REGS{1'b0}};
            reg_wdata  <= {DATA_W{1'b0}};
        end else begin
            // Strobes and the response pulse are single-cycle by default.
            sram_ren   <= 1'b0;
            sram_wen   <= 1'b0;
            reg_ren    <= {NUM_REGS{1'b0}};
            reg_wen    <= {NUM_REGS{1'b0}};
            scan_ready <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (scan_ren || scan_wen) begin
                        case (kind_s)
                            SRAM: begin
                                state_r    <= WAIT;
                                scan_busy  <= 1'b1;
                                cnt_r      <= {CNT_W{1'b0}};
                                tgt_sram_r <= 1'b1;
                                write_r    <= scan_wen;
                                sram_addr  <= scan_addr[SRAM_AW-1:0];
                                sram_wdata <= scan_wdata;
                                sram_ren   <= scan_ren;
                                sram_wen   <= scan_wen;
                            end
                            REG: begin
                                state_r    <= WAIT;
                                scan_busy  <= 1'b1;
                                cnt_r      <= {CNT_W{1'b0}};
                                tgt_sram_r <= 1'b0;
                                write_r    <= scan_wen;
                                reg_sel_r  <= reg_sel_s;
                                reg_wdata  <= scan_wdata;
                                reg_ren    <= reg_sel_s & {NUM_REGS{scan_ren}};
                                reg_wen    <= reg_sel_s & {NUM_REGS{scan_wen}};
                            end
                            STATUS: begin
                                scan_ready <= 1'b1;
                                scan_rdata <= status_in;
                                scan_err   <= 1'b0;
                            end
                            default: begin
                                scan_ready <= 1'b1;
                                scan_rdata <= {DATA_W{1'b0}};
                                scan_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    // A ready on the terminal count still completes successfully.
                    if (sel_ready_s) begin
                        state_r    <= IDLE;
                        scan_busy  <= 1'b0;
                        scan_ready <= 1'b1;
                        scan_rdata <= write_r ? {DATA_W{1'b0}} : sel_rdata_s;
                        scan_err   <= 1'b0;
                    end else if (cnt_r == CNT_TERM) begin
                        state_r    <= IDLE;
                        scan_busy  <= 1'b0;
                        scan_ready <= 1'b1;
                        scan_rdata <= {DATA_W{1'b0}};
                        scan_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/scan_bus_router.md
# scan_bus_router

Parametrised, registered router between the scan synchroniser's request port and the FFT SRAM plus a bank of NUM_REGS control registers and one read-only status word. It decodes each scan read/write, issues a single-cycle strobe to the selected target and waits for that target's ready. It then returns exactly one scan_ready pulse carrying read data and an error flag. Transactions to unmapped addresses, illegal requests and targets that never respond terminate with scan_err instead of hanging the scan chain.

## Interface
- ADDR_W, 11, scan address width; bit ADDR_W-1 selects SRAM (0) or register space (1)
- DATA_W, 32, data width
- SRAM_AW, 9, SRAM word address width (SRAM_AW <= ADDR_W-1)
- NUM_REGS, 4, number of control register targets (>= 1)
- TIMEOUT, 15, maximum wait cycles for a target ready (>= 1)
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- scan_ren / scan_wen  in  1  read / write request, sampled in IDLE only
- scan_addr  in  ADDR_W  request address
- scan_wdata  in  DATA_W  write data
- scan_rdata  out  DATA_W  response data, valid with scan_ready
- scan_ready  out  1  one-cycle response pulse
- scan_err  out  1  error flag, valid with scan_ready
- scan_busy  out  1  transaction in flight
- sram_ren / sram_wen  out  1  one-cycle SRAM strobes
- sram_addr  out  SRAM_AW  scan_addr[SRAM_AW-1:0], held for the transaction
- sram_wdata  out  DATA_W  write data, held for the transaction
- sram_rdata  in  DATA_W  SRAM read data, valid with sram_ready
- sram_ready  in  1  SRAM completion
- reg_ren / reg_wen  out  NUM_REGS  one-hot strobes
- reg_wdata  out  DATA_W  shared register write data
- reg_rdata  in  NUM_REGS*DATA_W  packed read data; register i is at slice [i*DATA_W +: DATA_W]
- reg_ready  in  NUM_REGS  per-register completion
- status_in  in  DATA_W  read-only status word (e.g. fft_done in bit 0)

## Operation
- States: IDLE and WAIT. scan_busy = (state == WAIT).
- In IDLE, when scan_ren or scan_wen is high, capture address, data and direction, then decode:
  - SRAM: scan_addr[ADDR_W-1] = 0. Bits ADDR_W-2:SRAM_AW are ignored. Go to WAIT.
  - Register: scan_addr[ADDR_W-1] = 1 and idx = scan_addr[IDX_W-1:0] < NUM_REGS, where IDX_W = $clog2(NUM_REGS+1). Go to WAIT.
  - Status read: idx == NUM_REGS with a read. Respond directly with scan_rdata = status_in and err = 0; stay in IDLE.
  - Error, responded directly with err = 1, rdata = 0, stay in IDLE:
    - idx > NUM_REGS;
    - a write to the status index;
    - scan_ren and scan_wen both high.
- In WAIT:
  - The target strobe is high in the first WAIT cycle only.
  - Each cycle, sample only the selected target's ready. On ready: scan_ready = 1, scan_rdata = target rdata (0 for writes), err = 0; return to IDLE.
- Timeout: the counter clears on entering WAIT and increments each WAIT cycle without ready. When it reaches TIMEOUT, respond with err = 1, rdata = 0 and return to IDLE.
- Ignored inputs:
  - Ready from a non-selected target, or any ready while in IDLE.
  - scan_ren/scan_wen while in WAIT; the requester must wait for scan_ready.
- Ready arriving in the same cycle as the timeout terminal count wins: the response is a success.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, counter is 0.
- rst mid-transaction drops the transaction: no scan_ready pulse is produced and strobes deassert the next cycle.
- Request sampled at cycle 0:
  - Target strobe at cycle 1.
  - Ready sampled at cycle k >= 1 gives scan_ready at cycle k+1. Minimum latency is 2 cycles.
  - Direct responses (status read, errors) give scan_ready at cycle 1.
- scan_ready is always exactly one cycle wide. scan_rdata and scan_err hold their values until the next response.
- The cycle in which scan_ready is high is an IDLE cycle, so back-to-back requests are accepted in that cycle.
- Timeout response arrives at cycle TIMEOUT+1 after the strobe.

## Structure
- Package scan_bus_pkg holds:
  - the state enum (IDLE, WAIT);
  - the target-kind enum (SRAM, REG, STATUS, ERR);
  - the region-select convention (MSB = register space).
- Sub-module scan_bus_decode: combinational decode of address and direction into target kind and index, instantiated once.
- The FSM, timeout counter and response registers live in the top module.

## Test plan
- Reset check: hold rst 2 cycles -> every output 0, scan_busy 0.
- SRAM write then read: write addr 0x005, data 0xDEADBEEF, sram_ready returned 2 cycles after the strobe -> sram_wen pulses 1 cycle with sram_addr 5; scan_ready 1 cycle after sram_ready with err 0. A following read returns 0xDEADBEEF.
- Register routing: write reg 2 (addr 0x402, wdata 0x5) -> only reg_wen[2] pulses. Read reg 0 -> scan_rdata equals reg_rdata slice 0.
- Status and unmapped: read addr 0x404 with status_in = 1 -> scan_ready at cycle 1, rdata 1. Write 0x404 -> err 1. Read 0x407 -> err 1, rdata 0, no strobes.
- Timeout and ordering: read reg 1 with reg_ready held 0 -> scan_ready with err 1 at cycle TIMEOUT+2 after the request. Ready exactly at the terminal count -> success. A request during WAIT is ignored.
- Abort and illegal request: rst asserted while in WAIT -> no scan_ready, state IDLE. scan_ren and scan_wen both high -> err 1 and no strobe issued.
